// File: rtl/lsu_map_pkg.sv
// LSU memory-map constants, load-op encoding and region decode, shared by load and store decode.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package lsu_map_pkg;

  // Region bases and masks. All decoding looks at addr[15:0] only.
  localparam logic [15:0] DMEM_BASE   = 16'h0800;
  localparam logic [15:0] DMEM_MASK   = 16'hF800;  // 0x0800-0x0FFF
  localparam logic [15:0] OUTBUF_BASE = 16'h1C00;
  localparam logic [15:0] OUTBUF_MASK = 16'hFFF0;  // 0x1C00-0x1C0F
  localparam logic [15:0] SW_ADDR     = 16'h1E08;
  localparam logic [15:0] KEY_ADDR    = 16'h1E0C;
  localparam logic [15:0] WORD_MASK   = 16'hFFFC;  // single-word registers ignore the byte lane

  // RV32I load funct3 encodings.
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_op_e;

  typedef enum logic [2:0] {
    RGN_NONE   = 3'd0,
    RGN_DMEM   = 3'd1,
    RGN_OUTBUF = 3'd2,
    RGN_SW     = 3'd3,
    RGN_KEY    = 3'd4
  } region_e;

  // Reserved encodings (011, 110, 111) behave as a full-word load.
  function automatic ld_op_e decode_op(input logic [2:0] f3);
    case (f3)
      3'b000:  decode_op = LD_LB;
      3'b001:  decode_op = LD_LH;
      3'b100:  decode_op = LD_LBU;
      3'b101:  decode_op = LD_LHU;
      default: decode_op = LD_LW;
    endcase
  endfunction

  // Unmapped addresses fall through to RGN_NONE and read as zero.
  function automatic region_e decode_region(input logic [15:0] addr);
    decode_region = RGN_NONE;
    if ((addr & DMEM_MASK) == DMEM_BASE) begin
      decode_region = RGN_DMEM;
    end else if ((addr & OUTBUF_MASK) == OUTBUF_BASE) begin
      decode_region = RGN_OUTBUF;
    end else if ((addr & WORD_MASK) == SW_ADDR) begin
      decode_region = RGN_SW;
    end else if ((addr & WORD_MASK) == KEY_ADDR) begin
      decode_region = RGN_KEY;
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single push-button conditioner: active-low raw input inverted, 2-FF synchronised, debounced.
// Latency: 2 sync cycles plus DEB_CYCLES-1 consecutive differing cycles before o_deb changes.
// Backpressure: none; free-running on every clock.
//
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_key_n         raw key, active-low, asynchronous
//   o_deb           debounced key state, 1 = pressed
//   o_press         (KEY_EDGE_EN only) one-cycle pulse in the cycle o_deb is about to rise
// Optional feature macro: KEY_EDGE_EN.
module key_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
`ifdef KEY_EDGE_EN
  output logic o_press,
`endif
  output logic o_deb
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  // The counter holds (differing cycles seen so far); the state flips on the
  // (DEB_CYCLES-1)th consecutive differing cycle.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEB_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // Invert first so that the all-zero reset state means "released".
    meta_d = ~i_key_n;
    sync_d = meta_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    if (sync_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_FIRE) begin
      deb_d = sync_q;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_deb = deb_q;

`ifdef KEY_EDGE_EN
  // Pulses alongside the update so a flag set from it becomes visible together with o_deb.
  assign o_press = deb_d & ~deb_q;
`endif

endmodule

// File: rtl/lsu_load_resp.sv
// LSU load responder: decodes the load address, selects dmem / output buffer / board inputs, extends.
// Latency: result, valid and misalign flag are registered, one cycle after i_ld_en.
// Backpressure: none; a request may be issued every cycle and is never stalled.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_ld_en          load request this cycle
//   i_lsu_addr       byte address, [15:0] decoded
//   i_funct3         RV32I load size/sign encoding
//   i_dmem_rdata     data-memory word at the request word address
//   i_outbuf_rdata   output-buffer word at the request word address
//   i_sw, i_key      raw switches and active-low keys (asynchronous)
//   o_ld_data        extended load result, held while o_ld_valid is low
//   o_ld_valid       result valid
//   o_ld_misalign    misaligned request flag, aligned with o_ld_valid
// Optional feature macro: KEY_EDGE_EN (sticky key-press flags in bits [15:8] of the key word).
module lsu_load_resp
  import lsu_map_pkg::*;
#(
  parameter int SW_W       = 18,
  parameter int KEY_W      = 4,
  parameter int DEB_CYCLES = 250000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_en,
  input  logic [31:0]       i_lsu_addr,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_dmem_rdata,
  input  logic [31:0]       i_outbuf_rdata,
  input  logic [SW_W-1:0]   i_sw,
  input  logic [KEY_W-1:0]  i_key,
  output logic [31:0]       o_ld_data,
  output logic              o_ld_valid,
  output logic              o_ld_misalign
);

  // Only the low half of the address is decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_lsu_addr[31:16];

  // ---------------------------------------------------------------------------
  // Board input conditioning
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
  logic [KEY_W-1:0] key_deb;

`ifdef KEY_EDGE_EN
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] flag_q, flag_d;
`endif

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_key_n (i_key[k]),
`ifdef KEY_EDGE_EN
      .o_press (key_press[k]),
`endif
      .o_deb   (key_deb[k])
    );
  end

  always_comb begin
    sw_meta_d = i_sw;
    sw_sync_d = sw_meta_q;
  end

  // ---------------------------------------------------------------------------
  // Decode, select, extend
  // ---------------------------------------------------------------------------
  ld_op_e      op;
  region_e     rgn;
  logic [31:0] sw_word;
  logic [31:0] key_word;
  logic [31:0] word_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        misalign;

  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        ld_misalign_q, ld_misalign_d;

  always_comb begin
    op  = decode_op(i_funct3);
    rgn = decode_region(i_lsu_addr[15:0]);

    sw_word               = '0;
    sw_word[SW_W-1:0]     = sw_sync_q;
    key_word              = '0;
    key_word[KEY_W-1:0]   = key_deb;
`ifdef KEY_EDGE_EN
    key_word[8 +: KEY_W]  = flag_q;
`endif

    case (rgn)
      RGN_DMEM:   word_sel = i_dmem_rdata;
      RGN_OUTBUF: word_sel = i_outbuf_rdata;
      RGN_SW:     word_sel = sw_word;
      RGN_KEY:    word_sel = key_word;
      default:    word_sel = '0;
    endcase

    ld_byte = word_sel[{i_lsu_addr[1:0], 3'b000} +: 8];
    ld_half = word_sel[{i_lsu_addr[1], 4'b0000} +: 16];

    case (op)
      LD_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_ext = {24'h0, ld_byte};
      LD_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_ext = {16'h0, ld_half};
      default: ld_ext = word_sel;
    endcase

    case (op)
      LD_LH, LD_LHU: misalign = i_lsu_addr[0];
      LD_LB, LD_LBU: misalign = 1'b0;
      default:       misalign = |i_lsu_addr[1:0];
    endcase

    // Idle cycles keep the previous result on the bus.
    ld_valid_d    = i_ld_en;
    ld_misalign_d = i_ld_en & misalign;
    ld_data_d     = ld_data_q;
    if (i_ld_en) begin
      ld_data_d = misalign ? 32'h0 : ld_ext;
    end
  end

`ifdef KEY_EDGE_EN
  // A press in the same cycle as a clearing read wins, so no event is lost.
  always_comb begin
    flag_d = flag_q;
    if (i_ld_en && (rgn == RGN_KEY)) begin
      flag_d = '0;
    end
    flag_d = flag_d | key_press;
  end
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      ld_data_q     <= '0;
      ld_valid_q    <= 1'b0;
      ld_misalign_q <= 1'b0;
`ifdef KEY_EDGE_EN
      flag_q        <= '0;
`endif
    end else begin
      sw_meta_q     <= sw_meta_d;
      sw_sync_q     <= sw_sync_d;
      ld_data_q     <= ld_data_d;
      ld_valid_q    <= ld_valid_d;
      ld_misalign_q <= ld_misalign_d;
`ifdef KEY_EDGE_EN
      flag_q        <= flag_d;
`endif
    end
  end

  assign o_ld_data     = ld_data_q;
  assign o_ld_valid    = ld_valid_q;
  assign o_ld_misalign = ld_misalign_q;

endmodule

// File: tb/tb_lsu_load_resp.sv
// Self-checking bench for lsu_load_resp: scoreboard of expected load results.
// Latency: each request expects its result one cycle later.
// Backpressure: none modelled; requests are issued freely.
module tb_lsu_load_resp;

  localparam int SW_W  = 18;
  localparam int KEY_W = 4;
  localparam int DEB   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_en;
  logic [31:0]      addr;
  logic [2:0]       f3;
  logic [31:0]      dmem;
  logic [31:0]      outbuf;
  logic [SW_W-1:0]  sw;
  logic [KEY_W-1:0] key;
  logic [31:0]      ld_data;
  logic             ld_valid;
  logic             ld_mis;

  always #5 clk = ~clk;

  lsu_load_resp #(
    .SW_W       (SW_W),
    .KEY_W      (KEY_W),
    .DEB_CYCLES (DEB)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_ld_en        (ld_en),
    .i_lsu_addr     (addr),
    .i_funct3       (f3),
    .i_dmem_rdata   (dmem),
    .i_outbuf_rdata (outbuf),
    .i_sw           (sw),
    .i_key          (key),
    .o_ld_data      (ld_data),
    .o_ld_valid     (ld_valid),
    .o_ld_misalign  (ld_mis)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
    logic        mis;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Drive one request for the current cycle and record its expected result.
  task automatic issue(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input logic m);
    ld_en = 1'b1;
    addr  = a;
    f3    = f;
    sb.push_back('{d, m});
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b0; addr = '0; f3 = '0;
    dmem = 32'hDEAD_BEEF; outbuf = 32'hCAFE_F00D;
    sw = '0; key = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ld_valid, ld_data, ld_mis} !== 34'h0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got v=%b d=%h m=%b, want all zero", i, ld_valid, ld_data, ld_mis);
      end
    end
  endtask

  task automatic test_decode();
    req_t t[$];
    exp_t e;
    dmem   = 32'h8765_43F1;
    outbuf = 32'h1234_ABCD;
    t.push_back('{32'h0000_0800, 3'b000, 32'hFFFF_FFF1, 1'b0});
    t.push_back('{32'h0000_0800, 3'b100, 32'h0000_00F1, 1'b0});
    t.push_back('{32'h0000_0802, 3'b001, 32'hFFFF_8765, 1'b0});
    t.push_back('{32'h0000_0802, 3'b101, 32'h0000_8765, 1'b0});
    t.push_back('{32'h0000_0803, 3'b000, 32'hFFFF_FF87, 1'b0});
    t.push_back('{32'h0000_0801, 3'b100, 32'h0000_0043, 1'b0});
    t.push_back('{32'h0000_0800, 3'b001, 32'h0000_43F1, 1'b0});
    t.push_back('{32'h0000_0FFC, 3'b010, 32'h8765_43F1, 1'b0});
    t.push_back('{32'hABCD_0800, 3'b010, 32'h8765_43F1, 1'b0});
    t.push_back('{32'h0000_0801, 3'b010, 32'h0000_0000, 1'b1});
    t.push_back('{32'h0000_0802, 3'b010, 32'h0000_0000, 1'b1});
    t.push_back('{32'h0000_0801, 3'b001, 32'h0000_0000, 1'b1});
    t.push_back('{32'h0000_1C03, 3'b101, 32'h0000_0000, 1'b1});
    t.push_back('{32'h0000_1C0C, 3'b010, 32'h1234_ABCD, 1'b0});
    t.push_back('{32'h0000_1C02, 3'b001, 32'h0000_1234, 1'b0});
    t.push_back('{32'h0000_1C01, 3'b000, 32'hFFFF_FFAB, 1'b0});
    t.push_back('{32'h0000_1234, 3'b010, 32'h0000_0000, 1'b0});
    t.push_back('{32'h0000_1000, 3'b010, 32'h0000_0000, 1'b0});
    t.push_back('{32'h0000_07FC, 3'b010, 32'h0000_0000, 1'b0});
    t.push_back('{32'h0000_1C10, 3'b010, 32'h0000_0000, 1'b0});
    t.push_back('{32'h0000_0800, 3'b011, 32'h8765_43F1, 1'b0});
    t.push_back('{32'h0000_0802, 3'b110, 32'h0000_0000, 1'b1});
    t.push_back('{32'h0000_0804, 3'b111, 32'h8765_43F1, 1'b0});
    foreach (t[i]) begin
      @(posedge clk); #1;
      issue(t[i].addr, t[i].f3, t[i].data, t[i].mis);
      @(posedge clk); #1;
      ld_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{32'hxxxx_xxxx, 1'bx};
      if ({ld_valid, ld_data, ld_mis} !== {1'b1, e.data, e.mis}) begin
        n_err++;
        $display("FAIL decode[%0d] addr=%h f3=%b: got v=%b d=%h m=%b, want v=1 d=%h m=%b",
                 i, t[i].addr, t[i].f3, ld_valid, ld_data, ld_mis, e.data, e.mis);
      end
      // Next idle cycle: valid drops, data holds.
      @(negedge clk);
      n_cmp++;
      if ({ld_valid, ld_data, ld_mis} !== {1'b0, e.data, 1'b0}) begin
        n_err++;
        $display("FAIL decode_idle[%0d]: got v=%b d=%h m=%b, want v=0 d=%h m=0",
                 i, ld_valid, ld_data, ld_mis, e.data);
      end
    end
  endtask

  task automatic test_switches();
    req_t t[$];
    exp_t e;
    sw = 18'h2A5A5;
    repeat (3) @(posedge clk);
    t.push_back('{32'h0000_1E08, 3'b010, 32'h0002_A5A5, 1'b0});
    t.push_back('{32'h0000_1E08, 3'b000, 32'hFFFF_FFA5, 1'b0});
    t.push_back('{32'h0000_1E09, 3'b100, 32'h0000_00A5, 1'b0});
    t.push_back('{32'h0000_1E0A, 3'b101, 32'h0000_0002, 1'b0});
    // Switch change in the request cycle must not be seen by that request.
    t.push_back('{32'h0000_1E08, 3'b010, 32'h0002_A5A5, 1'b0});
    t.push_back('{32'h0000_1E08, 3'b010, 32'h0001_5A5A, 1'b0});
    foreach (t[i]) begin
      if (i == 5) repeat (3) @(posedge clk);
      @(posedge clk); #1;
      issue(t[i].addr, t[i].f3, t[i].data, t[i].mis);
      if (i == 4) sw = 18'h15A5A;
      @(posedge clk); #1;
      ld_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{32'hxxxx_xxxx, 1'bx};
      if ({ld_valid, ld_data, ld_mis} !== {1'b1, e.data, e.mis}) begin
        n_err++;
        $display("FAIL switch[%0d] addr=%h: got v=%b d=%h m=%b, want v=1 d=%h m=%b",
                 i, t[i].addr, ld_valid, ld_data, ld_mis, e.data, e.mis);
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t t[$];
    exp_t e;
    int   n;
    t.push_back('{32'h0000_0800, 3'b010, 32'h8765_43F1, 1'b0});
    t.push_back('{32'h0000_1E08, 3'b010, 32'h0001_5A5A, 1'b0});
    t.push_back('{32'h0000_1C03, 3'b001, 32'h0000_0000, 1'b1});
    t.push_back('{32'h0000_1C00, 3'b100, 32'h0000_00CD, 1'b0});
    t.push_back('{32'h0000_2000, 3'b010, 32'h0000_0000, 1'b0});
    t.push_back('{32'h0000_0803, 3'b000, 32'hFFFF_FF87, 1'b0});
    n = t.size();
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (i < n) issue(t[i].addr, t[i].f3, t[i].data, t[i].mis);
      else ld_en = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{32'hxxxx_xxxx, 1'bx};
        if ({ld_valid, ld_data, ld_mis} !== {1'b1, e.data, e.mis}) begin
          n_err++;
          $display("FAIL b2b[%0d]: got v=%b d=%h m=%b, want v=1 d=%h m=%b",
                   i - 1, ld_valid, ld_data, ld_mis, e.data, e.mis);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({ld_valid, ld_data, ld_mis} !== {1'b0, 32'hFFFF_FF87, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_hold: got v=%b d=%h m=%b, want v=0 d=ffffff87 m=0", ld_valid, ld_data, ld_mis);
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    ld_en = 1'b1; addr = 32'h0000_0800; f3 = 3'b010;
    rst = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ld_valid, ld_data, ld_mis} !== 34'h0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b d=%h m=%b, want all zero", ld_valid, ld_data, ld_mis);
    end
  endtask

  task automatic test_debounce();
    exp_t        e;
    logic [31:0] pressed;
    int          glen[4] = '{3, 3, 3, 6};
`ifdef KEY_EDGE_EN
    pressed = 32'h0000_0101;
`else
    pressed = 32'h0000_0001;
`endif
    key = '1;
    repeat (4) @(posedge clk);
    // Glitches shorter than the debounce window never reach the debounced state.
    foreach (glen[g]) begin
      @(posedge clk); #1 key[0] = 1'b0;
      repeat (glen[g]) @(posedge clk);
      #1 key[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1 issue(32'h0000_1E0C, 3'b010, 32'h0, 1'b0);
      @(posedge clk); #1 ld_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{32'hxxxx_xxxx, 1'bx};
      if ({ld_valid, ld_data, ld_mis} !== {1'b1, e.data, e.mis}) begin
        n_err++;
        $display("FAIL glitch[%0d] len=%0d: got v=%b d=%h, want v=1 d=%h", g, glen[g], ld_valid, ld_data, e.data);
      end
    end
    // Held press: state flips exactly after sync (2) + DEB-1 differing cycles.
    @(posedge clk); #1 key[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 issue(32'h0000_1E0C, 3'b010, 32'h0, 1'b0);
    @(posedge clk); #1 issue(32'h0000_1E0C, 3'b010, pressed, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{32'hxxxx_xxxx, 1'bx};
    if ({ld_valid, ld_data} !== {1'b1, e.data}) begin
      n_err++;
      $display("FAIL deb_early: got v=%b d=%h, want v=1 d=%h", ld_valid, ld_data, e.data);
    end
    @(posedge clk); #1 ld_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{32'hxxxx_xxxx, 1'bx};
    if ({ld_valid, ld_data} !== {1'b1, e.data}) begin
      n_err++;
      $display("FAIL deb_pressed: got v=%b d=%h, want v=1 d=%h", ld_valid, ld_data, e.data);
    end
    // Release and let it settle back; any sticky flag was cleared by the read above.
    key[0] = 1'b1;
    repeat (12) @(posedge clk);
    #1 issue(32'h0000_1E0C, 3'b010, 32'h0, 1'b0);
    @(posedge clk); #1 ld_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{32'hxxxx_xxxx, 1'bx};
    if ({ld_valid, ld_data} !== {1'b1, e.data}) begin
      n_err++;
      $display("FAIL deb_released: got v=%b d=%h, want v=1 d=%h", ld_valid, ld_data, e.data);
    end
  endtask

`ifdef KEY_EDGE_EN
  task automatic test_key_edge();
    exp_t e;
    @(posedge clk); #1 key[1] = 1'b0;
    repeat (12) @(posedge clk);
    #1 issue(32'h0000_1E0C, 3'b010, 32'h0000_0202, 1'b0);
    @(posedge clk); #1 issue(32'h0000_1E0C, 3'b010, 32'h0000_0002, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{32'hxxxx_xxxx, 1'bx};
      if ({ld_valid, ld_data} !== {1'b1, e.data}) begin
        n_err++;
        $display("FAIL key_edge[%0d]: got v=%b d=%h, want v=1 d=%h", i, ld_valid, ld_data, e.data);
      end
      @(posedge clk); #1 ld_en = 1'b0;
    end
    key[1] = 1'b1;
    repeat (12) @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_switches();
    test_back_to_back();
    test_mid_reset();
    test_debounce();
`ifdef KEY_EDGE_EN
    test_key_edge();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
